cpu_run_ctrl: RTL and testbench

Run controller that sequences the single-cycle RISC-V core (control unit plus datapath).
- Loads a program into instruction memory through a streaming write port.
- Holds the core in reset during load, then runs, single-steps or halts it by gating the datapath clock enable.
- Detects the SYSTEM opcode (ecall/ebreak) to stop execution.
- Sits between the FPGA host/debug interface and the processor top level.

---
 rtl/cpu_ctrl_pkg.sv | 21 ++
 rtl/imem_loader.sv | 50 +++++
 rtl/cpu_run_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the run controller: FSM states, host command codes, SYSTEM opcode.
// No logic. Constants only.
// No flow control. Constants only.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        HALT = 3'd4
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imem_loader.sv
// Streams program words into instruction memory through a registered write port.
// Latency: a word accepted on edge N is written (imem_we=1) in the cycle after edge N.
// Backpressure: load_ready is low outside LOAD and while the final word's write is in flight.
module imem_loader #(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               en,
    input  logic               load_valid,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               done
);

    logic [IMEM_AW-1:0] idx;
    logic               fire;

    assign load_ready = en && !done;
    assign fire       = load_valid && load_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
        end else begin
            imem_we <= fire;
            // done marks the cycle in which the last word's write is on the port
            done    <= fire && load_last;
            if (start) begin
                idx <= '0;
            end else if (fire) begin
                idx <= idx + IMEM_AW'(1);
            end
            if (fire) begin
                imem_waddr <= idx;
                imem_wdata <= load_data;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads the program, then runs/steps/halts the core via cpu_en; watchdog under RUN_TIMEOUT_EN.
// Latency: commands take effect on the edge they are accepted; cpu_en follows opcode combinationally.
// Backpressure: cmd_ready low in LOAD and STEP; load_ready high only while loading.
module cpu_run_ctrl #(
    parameter int IMEM_AW    = 8,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    output logic               cmd_ready,
    input  logic               load_valid,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    input  logic [6:0]         opcode,
    output logic               cpu_en,
    output logic               cpu_rst_n,
    output logic               halted,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               timeout
);
    import cpu_ctrl_pkg::*;

    state_t st;
    logic   first_cycle;
    logic   cmd_fire;
    logic   fresh_start;
    logic   load_start;
    logic   halt_req;
    logic   load_done;
    logic   wd_fire;

    assign state       = st;
    assign cmd_ready   = (st == IDLE) || (st == RUN) || (st == HALT);
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign fresh_start = cmd_fire && (st == IDLE) && ((cmd_op == CMD_RUN) || (cmd_op == CMD_STEP));
    assign load_start  = cmd_fire && ((st == IDLE) || (st == HALT)) && (cmd_op == CMD_LOAD);

    // Resuming from HALT lets the instruction under the PC commit even if it is the ecall
    assign cpu_en   = (st == STEP) || ((st == RUN) && ((opcode != OPC_SYSTEM) || first_cycle));
    assign halt_req = (st == RUN) && (((opcode == OPC_SYSTEM) && !first_cycle)
                                      || (cmd_fire && (cmd_op == CMD_HALT)) || wd_fire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            cpu_rst_n   <= 1'b0;
            halted      <= 1'b0;
            first_cycle <= 1'b0;
            cycle_count <= '0;
        end else begin
            first_cycle <= 1'b0;
            if (fresh_start) begin
                cycle_count <= '0;
            end else if (cpu_en && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (load_start) begin
                st        <= LOAD;
                cpu_rst_n <= 1'b0;
                halted    <= 1'b0;
            end else begin
                case (st)
                    IDLE: if (fresh_start) begin
                        cpu_rst_n <= 1'b1;
                        if (cmd_op == CMD_RUN) st <= RUN;
                        else                   st <= STEP;
                    end
                    LOAD: if (load_done) st <= IDLE;
                    RUN: if (halt_req) begin
                        st     <= HALT;
                        halted <= 1'b1;
                    end
                    STEP: begin
                        st     <= HALT;
                        halted <= 1'b1;
                    end
                    HALT: if (cmd_fire && (cmd_op == CMD_RUN)) begin
                        st          <= RUN;
                        halted      <= 1'b0;
                        first_cycle <= 1'b1;
                    end else if (cmd_fire && (cmd_op == CMD_STEP)) begin
                        st     <= STEP;
                        halted <= 1'b0;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

`ifdef RUN_TIMEOUT_EN
    logic timeout_q;

    assign wd_fire = (st == RUN) && cpu_en && (cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (wd_fire) begin
            timeout_q <= 1'b1;
        end else if (fresh_start || load_start) begin
            timeout_q <= 1'b0;
        end
    end
`else
    // MAX_CYCLES only matters when the watchdog is built
    logic unused_max_cycles;
    assign unused_max_cycles = ^MAX_CYCLES;
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    imem_loader #(
        .IMEM_AW (IMEM_AW)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .start      (load_start),
        .en         (st == LOAD),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .done       (load_done)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: vector table for load/run/step/halt, plus reset-mid-load and watchdog sequences.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

`ifdef RUN_TIMEOUT_EN
    localparam int MAXC = 16;
`else
    localparam int MAXC = 1000000;
`endif

    localparam logic        N   = 1'b0;
    localparam logic        Y   = 1'b1;
    localparam logic [31:0] Z   = 32'd0;
    localparam logic [31:0] W0  = 32'h00500093;
    localparam logic [31:0] W1  = 32'h00100113;
    localparam logic [31:0] W2  = 32'h002081B3;
    localparam logic [31:0] W3  = 32'h00000073;
    localparam logic [31:0] WN  = 32'h00000013;
    localparam logic [6:0]  NOP = 7'h13;
    localparam logic [6:0]  ALU = 7'h33;
    localparam logic [6:0]  SYS = 7'h73;

    logic        clk, reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic        load_valid, load_last, load_ready;
    logic [31:0] load_data;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [6:0]  opcode;
    logic        cpu_en, cpu_rst_n, halted, timeout;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    cpu_run_ctrl #(.IMEM_AW(8), .CNT_W(32), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .opcode(opcode), .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n), .halted(halted),
        .state(state), .cycle_count(cycle_count), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [1:0]  op;
        logic        lv;
        logic [31:0] ld;
        logic        ll;
        logic [6:0]  opc;
        logic [2:0]  st;
        logic        en, rn, hl, we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        cr, lr;
        logic [31:0] cc;
    } vec_t;

    vec_t tbl[$];
    int   vecs = 0;
    int   miss = 0;

    task automatic add(input logic cv, input logic [1:0] op, input logic lv, input logic [31:0] ld,
                       input logic ll, input logic [6:0] opc, input logic [2:0] st, input logic en,
                       input logic rn, input logic hl, input logic we, input logic [7:0] wa,
                       input logic [31:0] wd, input logic cr, input logic lr, input logic [31:0] cc);
        vec_t v;
        v.cv = cv; v.op = op; v.lv = lv; v.ld = ld; v.ll = ll; v.opc = opc;
        v.st = st; v.en = en; v.rn = rn; v.hl = hl; v.we = we; v.wa = wa; v.wd = wd;
        v.cr = cr; v.lr = lr; v.cc = cc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_op = CMD_LOAD; load_valid = 1'b0; load_data = '0;
        load_last = 1'b0; opcode = NOP;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " state"}, 32'(state), 32'(IDLE));
        chk({tag, " imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, " imem_waddr"}, 32'(imem_waddr), 32'd0);
        chk({tag, " imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, " cpu_en"}, 32'(cpu_en), 32'd0);
        chk({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, " halted"}, 32'(halted), 32'd0);
        chk({tag, " cycle_count"}, cycle_count, 32'd0);
        chk({tag, " timeout"}, 32'(timeout), 32'd0);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " load_ready"}, 32'(load_ready), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic ok;
        bit   reached;

        // program load, run to ecall, step past it, reload
        add(Y,CMD_LOAD,N,Z,N,NOP,  IDLE,N,N,N,N,8'd0,Z, Y,N,32'd0);
        add(N,CMD_LOAD,Y,W0,N,NOP, LOAD,N,N,N,N,8'd0,Z, N,Y,32'd0);
        add(N,CMD_LOAD,Y,W1,N,NOP, LOAD,N,N,N,Y,8'd0,W0,N,Y,32'd0);
        add(N,CMD_LOAD,Y,W2,N,NOP, LOAD,N,N,N,Y,8'd1,W1,N,Y,32'd0);
        add(N,CMD_LOAD,Y,W3,Y,NOP, LOAD,N,N,N,Y,8'd2,W2,N,Y,32'd0);
        add(N,CMD_LOAD,N,Z,N,NOP,  LOAD,N,N,N,Y,8'd3,W3,N,N,32'd0);
        add(Y,CMD_RUN,N,Z,N,NOP,   IDLE,N,N,N,N,8'd3,W3,Y,N,32'd0);
        add(N,CMD_RUN,N,Z,N,NOP,   RUN, Y,Y,N,N,8'd3,W3,Y,N,32'd0);
        add(N,CMD_RUN,N,Z,N,NOP,   RUN, Y,Y,N,N,8'd3,W3,Y,N,32'd1);
        add(N,CMD_RUN,N,Z,N,ALU,   RUN, Y,Y,N,N,8'd3,W3,Y,N,32'd2);
        add(N,CMD_RUN,N,Z,N,SYS,   RUN, N,Y,N,N,8'd3,W3,Y,N,32'd3);
        add(N,CMD_RUN,N,Z,N,SYS,   HALT,N,Y,Y,N,8'd3,W3,Y,N,32'd3);
        add(Y,CMD_STEP,N,Z,N,SYS,  HALT,N,Y,Y,N,8'd3,W3,Y,N,32'd3);
        add(N,CMD_STEP,N,Z,N,SYS,  STEP,Y,Y,N,N,8'd3,W3,N,N,32'd3);
        add(N,CMD_STEP,N,Z,N,SYS,  HALT,N,Y,Y,N,8'd3,W3,Y,N,32'd4);
        add(Y,CMD_RUN,N,Z,N,SYS,   HALT,N,Y,Y,N,8'd3,W3,Y,N,32'd4);
        add(N,CMD_RUN,N,Z,N,SYS,   RUN, Y,Y,N,N,8'd3,W3,Y,N,32'd4);
        add(N,CMD_RUN,N,Z,N,SYS,   RUN, N,Y,N,N,8'd3,W3,Y,N,32'd5);
        add(Y,CMD_HALT,N,Z,N,SYS,  HALT,N,Y,Y,N,8'd3,W3,Y,N,32'd5);
        add(Y,CMD_LOAD,N,Z,N,SYS,  HALT,N,Y,Y,N,8'd3,W3,Y,N,32'd5);
        add(N,CMD_LOAD,Y,WN,Y,NOP, LOAD,N,N,N,N,8'd3,W3,N,Y,32'd5);
        add(N,CMD_LOAD,N,Z,N,NOP,  LOAD,N,N,N,Y,8'd0,WN,N,N,32'd5);
        add(Y,CMD_HALT,N,Z,N,NOP,  IDLE,N,N,N,N,8'd0,WN,Y,N,32'd5);
        add(Y,CMD_RUN,N,Z,N,ALU,   IDLE,N,N,N,N,8'd0,WN,Y,N,32'd5);
        // fresh run: 10 enabled cycles, LOAD/RUN ignored mid-run, then HALT commits the 11th
        for (int i = 0; i < 10; i++) begin
            add((i == 6 || i == 7) ? Y : N, (i == 6) ? CMD_LOAD : CMD_RUN, N, Z, N, ALU,
                RUN, Y, Y, N, N, 8'd0, WN, Y, N, 32'(i));
        end
        add(Y,CMD_HALT,N,Z,N,ALU,  RUN, Y,Y,N,N,8'd0,WN,Y,N,32'd10);
        add(N,CMD_HALT,N,Z,N,ALU,  HALT,N,Y,Y,N,8'd0,WN,Y,N,32'd11);
        add(Y,CMD_RUN,N,Z,N,ALU,   HALT,N,Y,Y,N,8'd0,WN,Y,N,32'd11);
        add(N,CMD_RUN,N,Z,N,ALU,   RUN, Y,Y,N,N,8'd0,WN,Y,N,32'd11);
        // ecall and HALT command together: single stop, ecall not committed
        add(Y,CMD_HALT,N,Z,N,SYS,  RUN, N,Y,N,N,8'd0,WN,Y,N,32'd12);
        add(N,CMD_HALT,N,Z,N,SYS,  HALT,N,Y,Y,N,8'd0,WN,Y,N,32'd12);
        add(N,CMD_HALT,N,Z,N,NOP,  HALT,N,Y,Y,N,8'd0,WN,Y,N,32'd12);

        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk_reset_values("reset");
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cmd_valid = v.cv; cmd_op = v.op; load_valid = v.lv; load_data = v.ld;
            load_last = v.ll; opcode = v.opc;
            #1;
            ok = (state === v.st) && (cpu_en === v.en) && (cpu_rst_n === v.rn) && (halted === v.hl)
                 && (imem_we === v.we) && (imem_waddr === v.wa) && (imem_wdata === v.wd)
                 && (cmd_ready === v.cr) && (load_ready === v.lr) && (cycle_count === v.cc)
                 && (timeout === 1'b0);
            vecs++;
            if (!ok) begin
                miss++;
                $display("FAIL vec%0d: got st=%0d en=%b rst_n=%b halted=%b we=%b wa=%0h wd=%h cr=%b lr=%b cc=%0d to=%b; expected st=%0d en=%b rst_n=%b halted=%b we=%b wa=%0h wd=%h cr=%b lr=%b cc=%0d to=0",
                         i, state, cpu_en, cpu_rst_n, halted, imem_we, imem_waddr, imem_wdata,
                         cmd_ready, load_ready, cycle_count, timeout,
                         v.st, v.en, v.rn, v.hl, v.we, v.wa, v.wd, v.cr, v.lr, v.cc);
            end
            tick();
        end

        // reset asserted mid-load after two words
        idle_inputs();
        cmd_valid = 1'b1; cmd_op = CMD_LOAD;
        tick();
        cmd_valid = 1'b0; load_valid = 1'b1; load_data = W0;
        tick();
        load_data = W1;
        tick();
        chk("midload we", 32'(imem_we), 32'd1);
        chk("midload waddr", 32'(imem_waddr), 32'd1);
        load_data = W2;
        #1 reset = 1'b0;
        #1;
        chk_reset_values("midload-reset");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset-held we", 32'(imem_we), 32'd0);
        end
        reset = 1'b1;
        tick();
        chk("post-reset state", 32'(state), 32'(IDLE));
        chk("post-reset we", 32'(imem_we), 32'd0);
        chk("post-reset load_ready", 32'(load_ready), 32'd0);

        // long run from a fresh start
        load_valid = 1'b0;
        cmd_valid = 1'b1; cmd_op = CMD_RUN; opcode = NOP;
        tick();
        cmd_valid = 1'b0;
`ifdef RUN_TIMEOUT_EN
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            tick();
            if (state == HALT) reached = 1'b1;
        end
        chk("watchdog halt reached", 32'(reached), 32'd1);
        chk("watchdog timeout", 32'(timeout), 32'd1);
        chk("watchdog halted", 32'(halted), 32'd1);
        chk("watchdog cycle_count", cycle_count, 32'd16);
        cmd_valid = 1'b1; cmd_op = CMD_LOAD;
        tick();
        cmd_valid = 1'b0;
        chk("timeout cleared by load", 32'(timeout), 32'd0);
        chk("state after reload cmd", 32'(state), 32'(LOAD));
`else
        reached = 1'b0;
        repeat (20) tick();
        chk("long run state", 32'(state), 32'(RUN));
        chk("long run cycle_count", cycle_count, 32'd20);
        chk("long run timeout", 32'(timeout), 32'd0);
        cmd_valid = 1'b1; cmd_op = CMD_HALT;
        tick();
        cmd_valid = 1'b0;
        chk("long run halted", 32'(halted), 32'd1);
        chk("long run final count", cycle_count, 32'd21);
        chk("long run no watchdog", 32'(reached), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
